// File: rtl/mio_bus_ctrl_if.sv
// CPU-to-slave bus controller interface: CPU request/response, slave select and data, error status.
// Ports: cpu_req/cpu_we/cpu_addr/cpu_wdata in; cpu_ready/cpu_rdata/cpu_err out.
// slv_sel/slv_we/slv_addr/slv_wdata out; slv_rdata/slv_ready in; err_addr/err_cnt status out.
interface mio_bus_ctrl_if #(
    parameter int N_SLV  = 4,
    parameter int DATA_W = 32
) ();
    logic                      cpu_req;
    logic                      cpu_we;
    logic [31:0]               cpu_addr;
    logic [DATA_W-1:0]         cpu_wdata;
    logic                      cpu_ready;
    logic [DATA_W-1:0]         cpu_rdata;
    logic                      cpu_err;
    logic [N_SLV-1:0]          slv_sel;
    logic                      slv_we;
    logic [31:0]               slv_addr;
    logic [DATA_W-1:0]         slv_wdata;
    logic [N_SLV*DATA_W-1:0]   slv_rdata;
    logic [N_SLV-1:0]          slv_ready;
    logic [31:0]               err_addr;
    logic [7:0]                err_cnt;

    // Controller view: masters the slave bus and answers the CPU.
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
        output cpu_ready, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata,
               err_addr, err_cnt
    );

    // Environment view: CPU plus slaves.
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
        input  cpu_ready, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata,
               err_addr, err_cnt
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Decodes a CPU request by addr[31:28] onto one of N_SLV slaves, waits for its ready or a timeout.
// Ports: clk, rst (sync, active-high), bus (mio_bus_ctrl_if.master).
// Latency: hit with immediate slave ready -> cpu_ready two cycles after acceptance; miss -> one cycle.
module mio_bus_ctrl #(
    parameter int                 N_SLV    = 4,
    parameter int                 DATA_W   = 32,
    parameter logic [4*N_SLV-1:0] SLV_BASE = {4'h0, 4'hd, 4'he, 4'hf},
    parameter int                 TIMEOUT  = 15
) (
    input  logic           clk,
    input  logic           rst,
    mio_bus_ctrl_if.master bus
);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [N_SLV-1:0]  dec_sel;
    logic              dec_hit;
    logic [N_SLV-1:0]  sel_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic [31:0]       err_addr_q;
    logic [7:0]        err_cnt_q;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout;

    // Region decode; scanning downward lets the lowest matching index win.
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (SLV_BASE[4*i +: 4] == bus.cpu_addr[31:28]) begin
                dec_sel    = '0;
                dec_sel[i] = 1'b1;
                dec_hit    = 1'b1;
            end
        end
    end

    // sel_q is one-hot, so an OR of masked lanes is a mux.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | bus.slv_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign sel_ready = |(bus.slv_ready & sel_q);
    assign timeout   = (cnt_q == TIMEOUT_C);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cpu_req) state_nxt = dec_hit ? ACCESS : RESP;
            ACCESS:  if (sel_ready || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction datapath and error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        addr_q  <= bus.cpu_addr;
                        we_q    <= bus.cpu_we;
                        wdata_q <= bus.cpu_wdata;
                        sel_q   <= dec_sel;
                        cnt_q   <= 8'd1;
                        rdata_q <= '0;
                        err_q   <= ~dec_hit;
                        if (!dec_hit) begin
                            err_addr_q <= bus.cpu_addr;
                            if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rdata_q <= we_q ? '0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q    <= '0;
                        err_q      <= 1'b1;
                        err_addr_q <= addr_q;
                        if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Outputs: response fields only visible in RESP, slave strobes only in ACCESS.
    always_comb begin
        bus.cpu_ready = (state == RESP);
        bus.cpu_rdata = (state == RESP) ? rdata_q : '0;
        bus.cpu_err   = (state == RESP) ? err_q : 1'b0;
        bus.slv_sel   = (state == ACCESS) ? sel_q : '0;
        bus.slv_we    = (state == ACCESS) ? we_q : 1'b0;
        bus.slv_addr  = addr_q;
        bus.slv_wdata = wdata_q;
        bus.err_addr  = err_addr_q;
        bus.err_cnt   = err_cnt_q;
    end
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: reset, read hit, slow write, miss, timeout,
// back-to-back misses with saturation, reset mid-access, decode priority with TIMEOUT=1.
module tb_mio_bus_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mio_bus_ctrl_if #(.N_SLV(4), .DATA_W(32)) bus ();
    mio_bus_ctrl_if #(.N_SLV(4), .DATA_W(32)) bus2 ();

    mio_bus_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // Duplicate regions (3 on slaves 0/1, 5 on slaves 2/3) and shortest timeout.
    mio_bus_ctrl #(.N_SLV(4), .DATA_W(32), .SLV_BASE(16'h5533), .TIMEOUT(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h7000_0000; bus.cpu_wdata = 32'h1111_2222;
        bus.slv_rdata = '0; bus.slv_ready = '0;
        bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0;
        bus2.cpu_wdata = '0; bus2.slv_rdata = '0; bus2.slv_ready = '0;
        step(); step();
        n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready got %b exp 0", bus.cpu_ready); end
        n_checks++; if (bus.cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_err got %b exp 0", bus.cpu_err); end
        n_checks++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h exp 0", bus.cpu_rdata); end
        n_checks++; if (bus.slv_sel !== 4'b0) begin n_fail++; $display("FAIL reset_slv_sel got %b exp 0000", bus.slv_sel); end
        n_checks++; if (bus.slv_we !== 1'b0) begin n_fail++; $display("FAIL reset_slv_we got %b exp 0", bus.slv_we); end
        n_checks++; if (bus.slv_addr !== 32'h0 || bus.slv_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_slv_addr_wdata got %h/%h exp 0/0", bus.slv_addr, bus.slv_wdata); end
        n_checks++; if (bus.err_addr !== 32'h0 || bus.err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err got %h/%0d exp 0/0", bus.err_addr, bus.err_cnt); end
        bus.cpu_req = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_hit();
        // Slave 0 ready before the request, unselected slave 1 also ready with other data.
        bus.slv_rdata = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hDEAD_0001, 32'h1234_5678};
        bus.slv_ready = 4'b0011;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hF000_0000;
        step(); // edge k: accepted, now ACCESS
        n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_k got %b exp 0", bus.cpu_ready); end
        n_checks++; if (bus.slv_sel !== 4'b0001 || bus.slv_we !== 1'b0) begin n_fail++; $display("FAIL rd_sel got %b we %b exp 0001 we 0", bus.slv_sel, bus.slv_we); end
        n_checks++; if (bus.slv_addr !== 32'hF000_0000) begin n_fail++; $display("FAIL rd_slv_addr got %h exp f0000000", bus.slv_addr); end
        step(); // edge k+1: RESP
        n_checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_err !== 1'b0) begin n_fail++; $display("FAIL rd_resp got ready %b err %b exp 1 0", bus.cpu_ready, bus.cpu_err); end
        n_checks++; if (bus.cpu_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata got %h exp 12345678", bus.cpu_rdata); end
        n_checks++; if (bus.slv_sel !== 4'b0) begin n_fail++; $display("FAIL rd_resp_sel got %b exp 0000", bus.slv_sel); end
        bus.cpu_req = 1'b0;
        step();
        n_checks++; if (bus.cpu_ready !== 1'b0 || bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_after got ready %b rdata %h exp 0 0", bus.cpu_ready, bus.cpu_rdata); end
        bus.slv_ready = '0;
    endtask

    task automatic test_write_slow();
        int pulses = 0;
        bus.slv_rdata = {32'h5555_5555, 32'h0, 32'h0, 32'h0};
        bus.slv_ready = 4'b0001; // unselected slave 0 ready: must be ignored
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h0000_0010; bus.cpu_wdata = 32'hCAFE_BABE;
        step();
        // Perturb CPU side after acceptance; transaction must stay intact.
        bus.cpu_req = 1'b0; bus.cpu_addr = 32'hF000_0000; bus.cpu_wdata = 32'h0BAD_0BAD; bus.cpu_we = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++; if (bus.slv_sel !== 4'b1000 || bus.slv_we !== 1'b1) begin n_fail++; $display("FAIL wr_sel_c%0d got %b we %b exp 1000 we 1", c, bus.slv_sel, bus.slv_we); end
            n_checks++; if (bus.slv_wdata !== 32'hCAFE_BABE || bus.slv_addr !== 32'h10) begin n_fail++; $display("FAIL wr_data_c%0d got %h @%h exp cafebabe @10", c, bus.slv_wdata, bus.slv_addr); end
            n_checks++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL wr_early_ready_c%0d got %b exp 0", c, bus.cpu_ready); end
            if (c == 3) bus.slv_ready = 4'b1001;
            step();
        end
        n_checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 32'h0 || bus.cpu_err !== 1'b0) begin n_fail++; $display("FAIL wr_resp got ready %b rdata %h err %b exp 1 0 0", bus.cpu_ready, bus.cpu_rdata, bus.cpu_err); end
        bus.slv_ready = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.cpu_ready === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL wr_extra_pulses got %0d exp 0", pulses); end
    endtask

    task automatic test_miss();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h7000_0000;
        step();
        n_checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_err !== 1'b1) begin n_fail++; $display("FAIL miss_resp got ready %b err %b exp 1 1", bus.cpu_ready, bus.cpu_err); end
        n_checks++; if (bus.slv_sel !== 4'b0 || bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL miss_sel_rdata got %b %h exp 0000 0", bus.slv_sel, bus.cpu_rdata); end
        n_checks++; if (bus.err_addr !== 32'h7000_0000 || bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL miss_err got %h/%0d exp 70000000/1", bus.err_addr, bus.err_cnt); end
        bus.cpu_req = 1'b0;
        step();
        n_checks++; if (bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0) begin n_fail++; $display("FAIL miss_after got ready %b err %b exp 0 0", bus.cpu_ready, bus.cpu_err); end
    endtask

    task automatic test_timeout();
        int n_acc = 0;
        int guard = 0;
        bus.slv_rdata = {32'h0, 32'h0, 32'h9999_9999, 32'h0};
        bus.slv_ready = 4'b1101; // everything but the selected slave 1
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hE000_0004;
        step();
        bus.cpu_req = 1'b0;
        while (bus.cpu_ready !== 1'b1 && guard < 40) begin
            if (bus.slv_sel === 4'b0010) n_acc++;
            guard++;
            step();
        end
        n_checks++; if (guard >= 40) begin n_fail++; $display("FAIL to_no_ready got none within %0d cycles exp ready", guard); end
        n_checks++; if (n_acc !== 15) begin n_fail++; $display("FAIL to_access_cycles got %0d exp 15", n_acc); end
        n_checks++; if (bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL to_resp got err %b rdata %h exp 1 0", bus.cpu_err, bus.cpu_rdata); end
        n_checks++; if (bus.err_cnt !== 8'd2 || bus.err_addr !== 32'hE000_0004) begin n_fail++; $display("FAIL to_err got %0d/%h exp 2/e0000004", bus.err_cnt, bus.err_addr); end
        bus.slv_ready = '0;
        step();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int doubles = 0;
        logic prev = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1000_0000;
        for (int c = 0; c < 600; c++) begin
            step();
            if (bus.cpu_ready === 1'b1) pulses++;
            if (bus.cpu_ready === 1'b1 && prev === 1'b1) doubles++;
            prev = bus.cpu_ready;
        end
        bus.cpu_req = 1'b0;
        n_checks++; if (pulses !== 300) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 300", pulses); end
        n_checks++; if (doubles !== 0) begin n_fail++; $display("FAIL b2b_consecutive got %0d exp 0", doubles); end
        n_checks++; if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err_cnt got %0d exp 255", bus.err_cnt); end
        n_checks++; if (bus.err_addr !== 32'h1000_0000) begin n_fail++; $display("FAIL sat_err_addr got %h exp 10000000", bus.err_addr); end
        step(); step();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'hD000_0020; bus.cpu_wdata = 32'h7777_8888;
        step();
        step();
        n_checks++; if (bus.slv_sel !== 4'b0100) begin n_fail++; $display("FAIL rstmid_sel got %b exp 0100", bus.slv_sel); end
        // Reset wins even with a request (to a missing region) present.
        rst = 1'b1; bus.cpu_addr = 32'h2000_0000;
        step();
        n_checks++; if (bus.cpu_ready !== 1'b0 || bus.slv_sel !== 4'b0 || bus.slv_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs got ready %b sel %b we %b exp 0 0000 0", bus.cpu_ready, bus.slv_sel, bus.slv_we); end
        n_checks++; if (bus.err_cnt !== 8'd0 || bus.err_addr !== 32'h0 || bus.slv_addr !== 32'h0 || bus.slv_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_regs got %0d %h %h %h exp all 0", bus.err_cnt, bus.err_addr, bus.slv_addr, bus.slv_wdata); end
        step();
        n_checks++; if (bus.cpu_ready !== 1'b0 || bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_priority got ready %b cnt %0d exp 0 0", bus.cpu_ready, bus.err_cnt); end
        bus.cpu_req = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.cpu_ready === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_pulse got %0d exp 0", pulses); end
    endtask

    task automatic test_priority();
        bus2.cpu_req = 1'b1; bus2.cpu_addr = 32'h5000_0000;
        step();
        bus2.cpu_req = 1'b0;
        n_checks++; if (bus2.slv_sel !== 4'b0100) begin n_fail++; $display("FAIL prio_5 got %b exp 0100", bus2.slv_sel); end
        step(); // TIMEOUT=1: no ready in first ACCESS cycle -> error
        n_checks++; if (bus2.cpu_ready !== 1'b1 || bus2.cpu_err !== 1'b1) begin n_fail++; $display("FAIL to1_resp got ready %b err %b exp 1 1", bus2.cpu_ready, bus2.cpu_err); end
        step();
        bus2.cpu_req = 1'b1; bus2.cpu_addr = 32'h3000_0000;
        step();
        bus2.cpu_req = 1'b0;
        n_checks++; if (bus2.slv_sel !== 4'b0001) begin n_fail++; $display("FAIL prio_3 got %b exp 0001", bus2.slv_sel); end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_slow();
        test_miss();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
